dmem_controller: RTL and testbench

- Sits directly downstream of the data cache: accepts cache-miss and write-through requests on per-consumer ports and arbitrates them onto NUM_CHANNELS independent external-memory channels.
- Each channel runs its own request FSM.
- One channel serves at most one consumer at a time, and one consumer is served by at most one channel.
- Responses are relayed back with a one-cycle ready pulse, after which the channel waits for valid to drop.

---
 rtl/dmem_controller.sv | 159 +++++++++++++++
 tb/tb_dmem_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_controller.sv
// rtl/dmem_controller.sv - arbitrates data-cache read/write requests onto independent memory channels
// Each channel runs its own IDLE/READ_WAITING/WRITE_WAITING/RELAYING FSM.
module dmem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CONSUMERS-1:0]          consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]          consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]          consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]          consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]           mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
    input  logic [NUM_CHANNELS-1:0]           mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
    output logic [NUM_CHANNELS-1:0]           mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
    input  logic [NUM_CHANNELS-1:0]           mem_write_ready
);
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {IDLE, READ_WAITING, WRITE_WAITING, RELAYING} state_t;

    state_t                           state_q [NUM_CHANNELS];
    state_t                           state_d [NUM_CHANNELS];
    logic [CW-1:0]                    cons_q  [NUM_CHANNELS];
    logic [CW-1:0]                    cons_d  [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]         served_q, served_d;
    logic [NUM_CHANNELS-1:0]          mrv_q, mrv_d, mwv_q, mwv_d;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] mra_q, mra_d, mwa_q, mwa_d;
    logic [NUM_CHANNELS*DATA_BITS-1:0] mwd_q, mwd_d;
    logic [NUM_CONSUMERS-1:0]         crr_q, crr_d, cwr_q, cwr_d;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] crd_q, crd_d;

    always_comb begin
        logic [NUM_CONSUMERS-1:0] taken;
        logic                     found;
        int                       pick;
        int                       ci;
        state_d  = state_q;
        cons_d   = cons_q;
        served_d = served_q;
        mrv_d    = mrv_q;
        mra_d    = mra_q;
        mwv_d    = mwv_q;
        mwa_d    = mwa_q;
        mwd_d    = mwd_q;
        crr_d    = '0;
        cwr_d    = '0;
        crd_d    = crd_q;
        // taken accumulates claims so lower channels win and no consumer is claimed twice
        taken    = served_q;
        found    = 1'b0;
        pick     = 0;
        ci       = 0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            ci = int'(cons_q[ch]);
            case (state_q[ch])
                IDLE: begin
                    found = 1'b0;
                    pick  = 0;
                    for (int c = 0; c < NUM_CONSUMERS; c++) begin
                        if (!found && !taken[c] && (consumer_read_valid[c] || consumer_write_valid[c])) begin
                            found = 1'b1;
                            pick  = c;
                        end
                    end
                    if (found) begin
                        taken[pick]    = 1'b1;
                        served_d[pick] = 1'b1;
                        cons_d[ch]     = CW'(pick);
                        if (consumer_read_valid[pick]) begin
                            mrv_d[ch] = 1'b1;
                            mra_d[ch*ADDR_BITS +: ADDR_BITS] = consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];
                            state_d[ch] = READ_WAITING;
                        end else begin
                            mwv_d[ch] = 1'b1;
                            mwa_d[ch*ADDR_BITS +: ADDR_BITS] = consumer_write_address[pick*ADDR_BITS +: ADDR_BITS];
                            mwd_d[ch*DATA_BITS +: DATA_BITS] = consumer_write_data[pick*DATA_BITS +: DATA_BITS];
                            state_d[ch] = WRITE_WAITING;
                        end
                    end
                end
                READ_WAITING: begin
                    if (mem_read_ready[ch]) begin
                        mrv_d[ch] = 1'b0;
                        crr_d[ci] = 1'b1;
                        crd_d[ci*DATA_BITS +: DATA_BITS] = mem_read_data[ch*DATA_BITS +: DATA_BITS];
                        state_d[ch] = RELAYING;
                    end
                end
                WRITE_WAITING: begin
                    if (mem_write_ready[ch]) begin
                        mwv_d[ch] = 1'b0;
                        cwr_d[ci] = 1'b1;
                        state_d[ch] = RELAYING;
                    end
                end
                RELAYING: begin
                    if (!consumer_read_valid[ci] && !consumer_write_valid[ci]) begin
                        served_d[ci] = 1'b0;
                        state_d[ch]  = IDLE;
                    end
                end
                default: state_d[ch] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= IDLE;
                cons_q[ch]  <= '0;
            end
            served_q <= '0;
            mrv_q    <= '0;
            mra_q    <= '0;
            mwv_q    <= '0;
            mwa_q    <= '0;
            mwd_q    <= '0;
            crr_q    <= '0;
            cwr_q    <= '0;
            crd_q    <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= state_d[ch];
                cons_q[ch]  <= cons_d[ch];
            end
            served_q <= served_d;
            mrv_q    <= mrv_d;
            mra_q    <= mra_d;
            mwv_q    <= mwv_d;
            mwa_q    <= mwa_d;
            mwd_q    <= mwd_d;
            crr_q    <= crr_d;
            cwr_q    <= cwr_d;
            crd_q    <= crd_d;
        end
    end

    assign mem_read_valid       = mrv_q;
    assign mem_read_address     = mra_q;
    assign mem_write_valid      = mwv_q;
    assign mem_write_address    = mwa_q;
    assign mem_write_data       = mwd_q;
    assign consumer_read_ready  = crr_q;
    assign consumer_read_data   = crd_q;
    assign consumer_write_ready = cwr_q;

endmodule

// File: tb/tb_dmem_controller.sv
// tb/tb_dmem_controller.sv - scoreboard bench for dmem_controller
module tb_dmem_controller;
    localparam int NCONS = 8;
    localparam int NCH   = 4;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NCONS-1:0] consumer_read_valid = '0;
    logic [NCONS*8-1:0] consumer_read_address = '0;
    logic [NCONS-1:0] consumer_read_ready;
    logic [NCONS*8-1:0] consumer_read_data;
    logic [NCONS-1:0] consumer_write_valid = '0;
    logic [NCONS*8-1:0] consumer_write_address = '0;
    logic [NCONS*8-1:0] consumer_write_data = '0;
    logic [NCONS-1:0] consumer_write_ready;
    logic [NCH-1:0]   mem_read_valid;
    logic [NCH*8-1:0] mem_read_address;
    logic [NCH-1:0]   mem_read_ready = '0;
    logic [NCH*8-1:0] mem_read_data = '0;
    logic [NCH-1:0]   mem_write_valid;
    logic [NCH*8-1:0] mem_write_address;
    logic [NCH*8-1:0] mem_write_data;
    logic [NCH-1:0]   mem_write_ready = '0;

    dmem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(NCONS), .NUM_CHANNELS(NCH)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
        .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
        .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
        .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_wr;
        int         cons;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   rd_cnt [NCONS];
    int   wr_cnt [NCONS];
    bit   auto_drop [NCONS];
    int   rcnt [NCH];
    int   wcnt [NCH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic match(input bit w, input int c, input logic [7:0] got);
        int idx = -1;
        for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].is_wr == w && sb[i].cons == c) idx = i;
        if (idx < 0) begin
            check(w ? "unexpected_wr_ready" : "unexpected_rd_ready", 32'(c), 32'hFFFF);
        end else begin
            if (!w) check("rd_data", {24'h0, got}, {24'h0, sb[idx].data});
            sb.delete(idx);
        end
    endtask

    // memory model with fixed latency plus consumer-side ready monitor
    initial begin
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < NCH; ch++) begin
                if (mem_read_ready[ch]) begin
                    mem_read_ready[ch] = 1'b0;
                    rcnt[ch] = 0;
                end else if (mem_read_valid[ch]) begin
                    rcnt[ch]++;
                    if (rcnt[ch] == LAT) begin
                        mem_read_ready[ch] = 1'b1;
                        mem_read_data[ch*8 +: 8] = mem_read_address[ch*8 +: 8] ^ 8'h18;
                    end
                end else rcnt[ch] = 0;
                if (mem_write_ready[ch]) begin
                    mem_write_ready[ch] = 1'b0;
                    wcnt[ch] = 0;
                end else if (mem_write_valid[ch]) begin
                    wcnt[ch]++;
                    if (wcnt[ch] == LAT) mem_write_ready[ch] = 1'b1;
                end else wcnt[ch] = 0;
            end
            for (int c = 0; c < NCONS; c++) begin
                if (consumer_read_ready[c]) begin
                    rd_cnt[c]++;
                    match(1'b0, c, consumer_read_data[c*8 +: 8]);
                    if (auto_drop[c]) consumer_read_valid[c] = 1'b0;
                end
                if (consumer_write_ready[c]) begin
                    wr_cnt[c]++;
                    match(1'b1, c, 8'h00);
                    if (auto_drop[c]) consumer_write_valid[c] = 1'b0;
                end
            end
        end
    end

    task automatic rd_req(input int c, input logic [7:0] a);
        exp_t e;
        consumer_read_address[c*8 +: 8] = a;
        consumer_read_valid[c] = 1'b1;
        e.is_wr = 1'b0; e.cons = c; e.data = a ^ 8'h18;
        sb.push_back(e);
    endtask

    task automatic wr_req(input int c, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        consumer_write_address[c*8 +: 8] = a;
        consumer_write_data[c*8 +: 8] = d;
        consumer_write_valid[c] = 1'b1;
        e.is_wr = 1'b1; e.cons = c; e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((sb.size() != 0 || mem_read_valid != 0 || mem_write_valid != 0) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(n < budget), 32'd1);
        tick();
        tick();
    endtask

    task automatic wait_rd(input string tag, input int c, input int budget);
        int n = 0;
        while (rd_cnt[c] == 0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_ready_seen"}, 32'(n < budget), 32'd1);
    endtask

    task automatic clear_counts();
        for (int c = 0; c < NCONS; c++) begin
            rd_cnt[c] = 0;
            wr_cnt[c] = 0;
        end
    endtask

    initial begin
        for (int c = 0; c < NCONS; c++) auto_drop[c] = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            rcnt[ch] = 0;
            wcnt[ch] = 0;
        end
        clear_counts();

        // reset with every request line asserted
        for (int c = 0; c < NCONS; c++) begin
            consumer_read_address[c*8 +: 8]  = 8'(8'h11 * c);
            consumer_write_address[c*8 +: 8] = 8'(8'h11 * c);
        end
        consumer_read_valid  = '1;
        consumer_write_valid = '1;
        tick();
        tick();
        check("rst_mem_rd_valid", 32'(mem_read_valid), 32'd0);
        check("rst_mem_wr_valid", 32'(mem_write_valid), 32'd0);
        check("rst_mem_rd_addr", mem_read_address, 32'd0);
        check("rst_cons_rd_ready", 32'(consumer_read_ready), 32'd0);
        check("rst_cons_wr_ready", 32'(consumer_write_ready), 32'd0);
        check("rst_cons_rd_data", consumer_read_data[31:0], 32'd0);
        reset = 1'b1;
        tick();
        check("post_rst_ch0_valid", 32'(mem_read_valid[0]), 32'd1);
        check("post_rst_ch1_addr", 32'(mem_read_address[15:8]), 32'h11);
        reset = 1'b0;
        tick();
        check("rerst_mem_rd_valid", 32'(mem_read_valid), 32'd0);
        consumer_read_valid  = '0;
        consumer_write_valid = '0;
        tick();
        reset = 1'b1;
        tick();
        check("rerst_no_ready", 32'({consumer_read_ready, consumer_write_ready}), 32'd0);

        // single read
        clear_counts();
        rd_req(3, 8'h42);
        tick();
        check("rd_issue_valid", 32'(mem_read_valid), 32'd1);
        check("rd_issue_addr", 32'(mem_read_address[7:0]), 32'h42);
        wait_done("single_rd", 50);
        check("single_rd_pulses", 32'(rd_cnt[3]), 32'd1);

        // single write
        clear_counts();
        wr_req(0, 8'h10, 8'h99);
        tick();
        check("wr_issue_valid", 32'(mem_write_valid), 32'd1);
        check("wr_issue_addr", 32'(mem_write_address[7:0]), 32'h10);
        check("wr_issue_data", 32'(mem_write_data[7:0]), 32'h99);
        tick();
        check("wr_hold_valid", 32'(mem_write_valid[0]), 32'd1);
        check("wr_hold_data", 32'(mem_write_data[7:0]), 32'h99);
        wait_done("single_wr", 50);
        check("single_wr_pulses", 32'(wr_cnt[0]), 32'd1);

        // contention: six readers, four channels
        clear_counts();
        for (int c = 0; c < 6; c++) rd_req(c, 8'(8'h80 + c));
        tick();
        check("cont_valids", 32'(mem_read_valid), 32'hF);
        for (int ch = 0; ch < NCH; ch++)
            check($sformatf("cont_ch%0d_addr", ch), 32'(mem_read_address[ch*8 +: 8]), 32'(8'h80 + ch));
        wait_done("contention", 200);
        for (int c = 0; c < 6; c++)
            check($sformatf("cont_c%0d_pulses", c), 32'(rd_cnt[c]), 32'd1);

        // held valid after ready
        clear_counts();
        auto_drop[1] = 1'b0;
        rd_req(1, 8'h33);
        wait_rd("held", 1, 50);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("held_no_req_%0d", i), 32'({mem_read_valid, mem_write_valid}), 32'd0);
        end
        consumer_read_valid[1] = 1'b0;
        auto_drop[1] = 1'b1;
        tick();
        tick();
        check("held_pulses", 32'(rd_cnt[1]), 32'd1);

        // read and write both asserted on consumer 2
        clear_counts();
        auto_drop[2] = 1'b0;
        consumer_write_address[2*8 +: 8] = 8'h30;
        consumer_write_data[2*8 +: 8]    = 8'h77;
        consumer_write_valid[2]          = 1'b1;
        rd_req(2, 8'h20);
        tick();
        check("rw_read_first", 32'(mem_read_valid), 32'd1);
        check("rw_no_write_yet", 32'(mem_write_valid), 32'd0);
        check("rw_read_addr", 32'(mem_read_address[7:0]), 32'h20);
        wait_rd("rw", 2, 50);
        tick();
        check("rw_relaying_no_write", 32'(mem_write_valid), 32'd0);
        consumer_read_valid[2]  = 1'b0;
        consumer_write_valid[2] = 1'b0;
        tick();
        auto_drop[2] = 1'b1;
        wr_req(2, 8'h30, 8'h77);
        tick();
        check("rw_write_valid", 32'(mem_write_valid), 32'd1);
        check("rw_write_addr", 32'(mem_write_address[7:0]), 32'h30);
        check("rw_write_data", 32'(mem_write_data[7:0]), 32'h77);
        wait_done("rw", 50);
        check("rw_rd_pulses", 32'(rd_cnt[2]), 32'd1);
        check("rw_wr_pulses", 32'(wr_cnt[2]), 32'd1);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
